alu_op_driver: RTL
==================

// Module: alu_op_driver
// PURPOSE
//   Sequential initiator for the lab's combinational N-bit ALU (Function 00 add, 01 OR-reduce,
//   10 AND-reduce, 11 concat {A,B}; 2N-bit result). Accepts one operation request over a
//   valid/ready handshake and registers the operands onto the ALU input ports. It waits a fixed
//   settle time, captures ALUOut and presents it on a valid/ready response port.
//   Sits between a datapath/controller and the ALU so downstream logic only ever sees registered results.
// PARAMETERS
//   N              4   operand width; result width is 2*N
//   SETTLE_CYCLES  1   cycles ALU inputs are held before ALUOut is captured; must be >=1 (elaboration $error if 0)
// PORTS
//   Clock         in   1      single clock, all state updates on posedge
//   Reset         in   1      synchronous, active-high
//   ReqValid      in   1      request present
//   ReqReady      out  1      block can accept a request (1 only in IDLE)
//   ReqA          in   N      operand A
//   ReqB          in   N      operand B
//   ReqFunction   in   2      ALU function code
//   ALU_A         out  N      registered drive to ALU A
//   ALU_B         out  N      registered drive to ALU B
//   ALU_Function  out  2      registered drive to ALU Function
//   ALUOut        in   2N     ALU result (combinational from ALU_*)
//   RespValid     out  1      RespData holds a captured result
//   RespReady     in   1      consumer accepts result
//   RespData      out  2N     captured result
//   OpCount       out  8      completed responses, wraps 255->0
// BEHAVIOUR
//   - Reset (on posedge with Reset=1): state IDLE; ALU_A/ALU_B/ALU_Function=0, RespValid=0, RespData=0,
//     OpCount=0, settle counter=0. Reset mid-operation aborts it; no response is produced.
//   - FSM: IDLE -> SETTLE -> RESP -> IDLE. ReqReady = (state==IDLE), combinational from state.
//   - IDLE: at edge E0 with ReqValid&&ReqReady, latch ReqA/ReqB/ReqFunction into ALU_*, load counter=SETTLE_CYCLES-1,
//     go SETTLE. ReqValid without ReqReady is ignored (no queueing).
//   - SETTLE: counter decrements each edge; at the edge where counter==0 (edge E0+SETTLE_CYCLES),
//     RespData<=ALUOut, RespValid<=1, go RESP. Total accept-to-RespValid latency = SETTLE_CYCLES+1 edges... i.e.
//     RespValid first observed high after edge E0+SETTLE_CYCLES.
//   - RESP: RespData, RespValid, ALU_* held stable while RespReady=0. At edge with RespValid&&RespReady:
//     RespValid<=0, OpCount<=OpCount+1 (mod 256), go IDLE. No new request is accepted in the same edge.
//   - ALU_* keep last driven values after completion (not cleared) until next accept or Reset.
//   - Width rules: RespData is full 2N bits of ALUOut, no truncation; OpCount 8-bit wrap.
//   - Reset has priority over every other event in the same cycle.
// CONFIGURATION
//   ALU_DRV_ACCUM_EN defined: adds input port ReqAccum (1 bit) and an N-bit accumulator register Acc
//     (reset 0, loaded with ALUOut[N-1:0] at every capture edge). If ReqAccum=1 at accept, ALU_B<=Acc instead of ReqB.
//   ALU_DRV_ACCUM_EN undefined: no ReqAccum port, no Acc register; ALU_B always loaded from ReqB.
// TESTING (bench: N=4, real lab ALU on ALU_*/ALUOut, SETTLE_CYCLES=1 unless stated)
//   1. Reset, then A=3 B=5 F=00, RespReady=1 -> accept at E0, RespValid=1 after E0+1, RespData=8'h08,
//      OpCount=1 after handshake, ReqReady=1 next cycle.
//   2. A=4'hA B=4'h5 F=11, RespReady=0 for 5 cycles, ReqValid=1 throughout -> RespData=8'hA5 stable,
//      ReqReady=0, ALU_* unchanged; RespReady=1 -> IDLE, second request accepted next edge.
//   3. F=01 A=0 B=0 -> 8'h00; F=01 A=0 B=1 -> 8'h01; F=10 A=F B=F -> 8'h01; F=10 A=F B=E -> 8'h00.
//   4. SETTLE_CYCLES=4 build: Reset pulsed 2 cycles after accept -> RespValid=0, ReqReady=1, ALU_*=0,
//      OpCount=0, no response ever issued for aborted op; accept-to-RespValid = after E0+4 on clean op.
//   5. 256 back-to-back ops with RespReady=1 -> OpCount returns to 0; 257th -> 1.
//   6. ALU_DRV_ACCUM_EN: op A=3 B=5 F=00 (Acc<=8), then A=1 F=00 ReqAccum=1 -> ALU_B=4'h8, RespData=8'h09;
//      without macro, same sequence with ReqB=2 -> RespData=8'h03.

Source files
------------

// File: rtl/alu_op_driver.sv
// alu_op_driver: registered request/response wrapper around a combinational N-bit ALU with a fixed settle delay.
// Optional accumulator feedback onto ALU_B is enabled by defining ALU_DRV_ACCUM_EN.
module alu_op_driver #(
  parameter int N = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic [N-1:0]   ReqA,
  input  logic [N-1:0]   ReqB,
  input  logic [1:0]     ReqFunction,
`ifdef ALU_DRV_ACCUM_EN
  input  logic           ReqAccum,
`endif
  output logic [N-1:0]   ALU_A,
  output logic [N-1:0]   ALU_B,
  output logic [1:0]     ALU_Function,
  input  logic [2*N-1:0] ALUOut,
  output logic           RespValid,
  input  logic           RespReady,
  output logic [2*N-1:0] RespData,
  output logic [7:0]     OpCount
);
  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("alu_op_driver: SETTLE_CYCLES must be >= 1");
    end
  endgenerate
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0] b_src;
  logic accept, settle_done, resp_done;
  assign ReqReady    = state == IDLE;
  assign accept      = ReqValid && ReqReady;
  assign settle_done = state == SETTLE && cnt == '0;
  assign resp_done   = state == RESP && RespValid && RespReady;
`ifdef ALU_DRV_ACCUM_EN
  logic [N-1:0] acc;
  assign b_src = ReqAccum ? acc : ReqB;
  always_ff @(posedge Clock)
    if (Reset) acc <= '0;
    else if (settle_done) acc <= ALUOut[N-1:0];
`else
  assign b_src = ReqB;
`endif
  always_comb begin
    state_nx = state;
    state_nx = accept ? SETTLE : settle_done ? RESP : resp_done ? IDLE : state;
  end
  always_ff @(posedge Clock)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ALU_A        <= '0;
      ALU_B        <= '0;
      ALU_Function <= '0;
      RespValid    <= 1'b0;
      RespData     <= '0;
      OpCount      <= '0;
      cnt          <= '0;
    end else begin
      if (accept) begin
        ALU_A        <= ReqA;
        ALU_B        <= b_src;
        ALU_Function <= ReqFunction;
        cnt          <= CNT_LOAD;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (settle_done) begin
        RespData  <= ALUOut;
        RespValid <= 1'b1;
      end
      if (resp_done) begin
        RespValid <= 1'b0;
        OpCount   <= OpCount + 8'd1;
      end
    end
  end
endmodule
